// File: rtl/score_argmax_if.sv
// rtl/score_argmax_if.sv - score vector in / argmax result out handshake bundle (margin port under ARGMAX_MARGIN_EN)
interface score_argmax_if #(
    parameter int N_CLASSES = 10,
    parameter int SCORE_W   = 16,
    parameter int IDX_W     = 4
);
    logic                      in_valid;
    logic                      in_ready;
    logic signed [SCORE_W-1:0] scores [N_CLASSES-1:0];
    logic                      out_valid;
    logic                      out_ready;
    logic [IDX_W-1:0]          class_id;
    logic signed [SCORE_W-1:0] max_score;
`ifdef ARGMAX_MARGIN_EN
    logic [SCORE_W-1:0]        margin;
`endif

    // Producer of score vectors and consumer of results
    modport master (
        output in_valid,
        output scores,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  class_id,
        input  max_score
`ifdef ARGMAX_MARGIN_EN
        , input margin
`endif
    );

    // The argmax block itself
    modport slave (
        input  in_valid,
        input  scores,
        input  out_ready,
        output in_ready,
        output out_valid,
        output class_id,
        output max_score
`ifdef ARGMAX_MARGIN_EN
        , output margin
`endif
    );
endinterface

// File: rtl/score_argmax.sv
// rtl/score_argmax.sv - sequential argmax over one score vector; ARGMAX_MARGIN_EN adds a max-minus-runner-up margin
module score_argmax #(
    parameter int N_CLASSES = 10,
    parameter int SCORE_W   = 16,
    parameter int IDX_W     = 4
) (
    input  logic         clk,
    input  logic         reset,
    score_argmax_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [IDX_W-1:0]          LAST_IDX  = IDX_W'(N_CLASSES - 1);
    localparam logic signed [SCORE_W-1:0] MIN_SCORE = {1'b1, {(SCORE_W-1){1'b0}}};

    state_t                    state;
    state_t                    state_nxt;
    logic                      in_ready;
    logic                      out_valid;
    logic                      accept;
    logic                      finish;

    logic signed [SCORE_W-1:0] score_buf [N_CLASSES];
    logic [IDX_W-1:0]          idx;
    logic signed [SCORE_W-1:0] best;
    logic [IDX_W-1:0]          best_idx;
    logic signed [SCORE_W-1:0] cand;
    logic                      take_best;
    logic signed [SCORE_W-1:0] best_nxt;
    logic [IDX_W-1:0]          best_idx_nxt;

    logic [IDX_W-1:0]          class_id_q;
    logic signed [SCORE_W-1:0] max_score_q;

`ifdef ARGMAX_MARGIN_EN
    logic signed [SCORE_W-1:0] second;
    logic signed [SCORE_W-1:0] second_nxt;
    logic [SCORE_W-1:0]        margin_q;
`endif

    assign accept = (state == IDLE) && bus.in_valid;
    assign finish = (state == SCAN) && (idx == LAST_IDX);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One compare per cycle; strictly-greater so ties keep the lower index
    always_comb begin
        cand         = score_buf[idx];
        take_best    = (cand > best);
        best_nxt     = take_best ? cand : best;
        best_idx_nxt = take_best ? idx : best_idx;
`ifdef ARGMAX_MARGIN_EN
        second_nxt   = second;
        if (take_best) begin
            second_nxt = best;
        end else if (cand > second) begin
            second_nxt = cand;
        end
`endif
    end

    // Capture the vector, run the scan, and latch results on the final scan edge
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CLASSES; i++) begin
                score_buf[i] <= '0;
            end
            idx         <= '0;
            best        <= '0;
            best_idx    <= '0;
            class_id_q  <= '0;
            max_score_q <= '0;
`ifdef ARGMAX_MARGIN_EN
            second      <= '0;
            margin_q    <= '0;
`endif
        end else if (accept) begin
            for (int i = 0; i < N_CLASSES; i++) begin
                score_buf[i] <= bus.scores[i];
            end
            best     <= bus.scores[0];
            best_idx <= '0;
            idx      <= IDX_W'(1);
`ifdef ARGMAX_MARGIN_EN
            second   <= MIN_SCORE;
`endif
        end else if (state == SCAN) begin
            best     <= best_nxt;
            best_idx <= best_idx_nxt;
            idx      <= idx + IDX_W'(1);
`ifdef ARGMAX_MARGIN_EN
            second   <= second_nxt;
`endif
            if (finish) begin
                class_id_q  <= best_idx_nxt;
                max_score_q <= best_nxt;
`ifdef ARGMAX_MARGIN_EN
                margin_q    <= SCORE_W'(best_nxt - second_nxt);
`endif
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.class_id  = class_id_q;
    assign bus.max_score = max_score_q;
`ifdef ARGMAX_MARGIN_EN
    assign bus.margin    = margin_q;
`endif

endmodule

// File: tb/tb_score_argmax.sv
// tb/tb_score_argmax.sv - directed self-checking bench for score_argmax
module tb_score_argmax;
    logic clk;
    logic reset;

    score_argmax_if bus ();

    score_argmax dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic signed [15:0] vec [10];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present();
        for (int i = 0; i < 10; i++) begin
            bus.scores[i] = vec[i];
        end
        bus.in_valid = 1'b1;
    endtask

    task automatic wait_result(input string tag, input logic [15:0] ec,
                               input logic [15:0] em, input logic [15:0] eg);
        int cnt;
        cnt = 0;
        while (!bus.out_valid && cnt < 40) begin
            tick();
            cnt++;
        end
        check({tag, " latency"}, 16'(cnt), 16'd9);
        check({tag, " class_id"}, 16'(bus.class_id), ec);
        check({tag, " max_score"}, bus.max_score, em);
`ifdef ARGMAX_MARGIN_EN
        check({tag, " margin"}, bus.margin, eg);
`else
        if (eg != eg) $display("unreachable");
`endif
    endtask

    task automatic run_vector(input string tag, input logic [15:0] ec,
                              input logic [15:0] em, input logic [15:0] eg);
        check({tag, " in_ready"}, 16'(bus.in_ready), 16'd1);
        present();
        tick();
        bus.in_valid = 1'b0;
        wait_result(tag, ec, em, eg);
    endtask

    task automatic consume(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, " out_valid after take"}, 16'(bus.out_valid), 16'd0);
        check({tag, " in_ready after take"}, 16'(bus.in_ready), 16'd1);
    endtask

    logic signed [15:0] b2b [3][10];
    logic [15:0]        b2b_class [3];
    logic [15:0]        b2b_max [3];

    initial begin
        logic stable;
        logic will_acc;
        int acc;
        int got;
        int cyc;
        int last_t;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) bus.scores[i] = '0;
        tick();
        tick();
        reset = 1'b0;

        check("reset in_ready", 16'(bus.in_ready), 16'd1);
        check("reset out_valid", 16'(bus.out_valid), 16'd0);
        check("reset class_id", 16'(bus.class_id), 16'd0);
        check("reset max_score", bus.max_score, 16'd0);
`ifdef ARGMAX_MARGIN_EN
        check("reset margin", bus.margin, 16'd0);
`endif

        vec = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sh0100, 16'sd0, 16'sd0};
        run_vector("t1", 16'd7, 16'h0100, 16'h0100);
        consume("t1");

        vec = '{16'sd5, 16'sd3, 16'sd9, 16'sd9, 16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
        run_vector("t2 tie", 16'd2, 16'd9, 16'd0);
        consume("t2");

        for (int i = 0; i < 10; i++) vec[i] = 16'sh8000;
        run_vector("t3 all min", 16'd0, 16'h8000, 16'd0);
        consume("t3a");

        vec[0] = 16'shFFFF;
        run_vector("t3 neg1", 16'd0, 16'hFFFF, 16'h7FFF);
        consume("t3b");

        vec = '{16'sd10, 16'sd20, 16'sd30, 16'sd100, 16'sd40, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
        run_vector("t4 A", 16'd3, 16'd100, 16'd60);
        vec = '{-16'sd5, -16'sd3, -16'sd7, -16'sd4, -16'sd9, -16'sd2, -16'sd8, -16'sd6, -16'sd1, -16'sd10};
        present();
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.class_id != 4'd3 || bus.max_score != 16'sd100 || bus.in_ready || !bus.out_valid)
                stable = 1'b0;
        end
        check("t4 hold stable", 16'(stable), 16'd1);
        consume("t4");
        tick();
        bus.in_valid = 1'b0;
        wait_result("t4 B", 16'd8, 16'hFFFF, 16'd1);
        consume("t4 B");

        vec = '{16'sd500, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
        present();
        tick();
        bus.in_valid = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5 out_valid", 16'(bus.out_valid), 16'd0);
        check("t5 in_ready", 16'(bus.in_ready), 16'd1);
        check("t5 class_id", 16'(bus.class_id), 16'd0);
        vec = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6, 16'sd7, 16'sd8, 16'sd9, 16'sd50};
        run_vector("t5 post", 16'd9, 16'd50, 16'd41);
        consume("t5");

        b2b[0] = '{16'sd0, 16'sd7, 16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6, 16'sd0, 16'sd0};
        b2b[1] = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd33, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
        b2b[2] = '{-16'sd9, -16'sd9, -16'sd9, -16'sd9, -16'sd9, -16'sd9, -16'sd9, -16'sd9, -16'sd9, -16'sd3};
        b2b_class = '{16'd1, 16'd4, 16'd9};
        b2b_max   = '{16'd7, 16'd33, 16'hFFFD};
        vec = b2b[0];
        present();
        bus.out_ready = 1'b1;
        acc = 0;
        got = 0;
        cyc = 0;
        last_t = 0;
        while (got < 3 && cyc < 100) begin
            will_acc = bus.in_ready && bus.in_valid;
            tick();
            cyc++;
            if (will_acc) begin
                acc++;
                if (acc < 3) begin
                    vec = b2b[acc];
                    present();
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            if (bus.out_valid) begin
                check($sformatf("t6 class_id %0d", got), 16'(bus.class_id), b2b_class[got]);
                check($sformatf("t6 max_score %0d", got), bus.max_score, b2b_max[got]);
                if (got > 0) check($sformatf("t6 gap %0d", got), 16'(cyc - last_t), 16'd11);
                last_t = cyc;
                got++;
            end
        end
        check("t6 result count", 16'(got), 16'd3);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
